// File: rtl/mem_req_pkg.sv
// Shared types and constants for the 2:1 memory request arbiter.
package mem_req_pkg;

  typedef logic route_id_t;

  localparam route_id_t CH0 = 1'b0;
  localparam route_id_t CH1 = 1'b1;

  localparam logic WEN_STORE = 1'b0;
  localparam logic WEN_LOAD  = 1'b1;

endpackage

// File: rtl/mem_route_fifo.sv
// Small FIFO remembering which channel owns each outstanding memory response.
module mem_route_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Explicit wrap keeps DEPTH=1 correct, where the pointer is wider than needed.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        slots_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter_2to1.sv
// Round-robin 2:1 arbiter onto one memory port, steering responses back in grant order.
module mem_req_arbiter_2to1
  import mem_req_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ch0_req_i,
  input  logic [ADDR_WIDTH-1:0] ch0_add_i,
  input  logic                  ch0_wen_i,
  input  logic [DATA_WIDTH-1:0] ch0_wdata_i,
  input  logic [BE_WIDTH-1:0]   ch0_be_i,
  output logic                  ch0_gnt_o,
  output logic                  ch0_r_valid_o,
  output logic [DATA_WIDTH-1:0] ch0_r_rdata_o,

  input  logic                  ch1_req_i,
  input  logic [ADDR_WIDTH-1:0] ch1_add_i,
  input  logic                  ch1_wen_i,
  input  logic [DATA_WIDTH-1:0] ch1_wdata_i,
  input  logic [BE_WIDTH-1:0]   ch1_be_i,
  output logic                  ch1_gnt_o,
  output logic                  ch1_r_valid_o,
  output logic [DATA_WIDTH-1:0] ch1_r_rdata_o,

  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,

  output logic                  err_o
);

  route_id_t sel;
  route_id_t last_grant_q;
  route_id_t head;
  logic      fifo_full, fifo_empty;
  logic      handshake, pop;
  logic      err_q;

  always_comb begin
    if (ch0_req_i && ch1_req_i) begin
      sel = ~last_grant_q;
    end else if (ch1_req_i) begin
      sel = CH1;
    end else begin
      sel = CH0;
    end
  end

  assign data_req_o = (ch0_req_i | ch1_req_i) & ~fifo_full & rst_n;
  assign handshake  = data_req_o & data_gnt_i;

  always_comb begin
    if (sel == CH1) begin
      data_add_o   = ch1_add_i;
      data_wen_o   = ch1_wen_i;
      data_wdata_o = ch1_wdata_i;
      data_be_o    = ch1_be_i;
    end else begin
      data_add_o   = ch0_add_i;
      data_wen_o   = ch0_wen_i;
      data_wdata_o = ch0_wdata_i;
      data_be_o    = ch0_be_i;
    end
  end

  assign ch0_gnt_o = handshake & (sel == CH0);
  assign ch1_gnt_o = handshake & (sel == CH1);

  // Responses with no owner are dropped here and flagged below.
  assign pop           = data_r_valid_i & ~fifo_empty & rst_n;
  assign ch0_r_valid_o = pop & (head == CH0);
  assign ch1_r_valid_o = pop & (head == CH1);
  assign ch0_r_rdata_o = data_r_rdata_i;
  assign ch1_r_rdata_o = data_r_rdata_i;
  assign err_o         = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= CH1;
      err_q        <= 1'b0;
    end else begin
      if (handshake) begin
        last_grant_q <= sel;
      end
      if (data_r_valid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  mem_route_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_route_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (handshake),
    .push_data (sel),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter_2to1.sv
// Scoreboard bench: directed requests, a simple memory model, and a grant/response monitor.
module tb_mem_req_arbiter_2to1;
  import mem_req_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ch0_req_i, ch0_wen_i, ch0_gnt_o, ch0_r_valid_o;
  logic [AW-1:0] ch0_add_i;
  logic [DW-1:0] ch0_wdata_i, ch0_r_rdata_o;
  logic [BW-1:0] ch0_be_i;
  logic          ch1_req_i, ch1_wen_i, ch1_gnt_o, ch1_r_valid_o;
  logic [AW-1:0] ch1_add_i;
  logic [DW-1:0] ch1_wdata_i, ch1_r_rdata_o;
  logic [BW-1:0] ch1_be_i;
  logic          data_req_o, data_wen_o;
  logic [AW-1:0] data_add_o;
  logic [DW-1:0] data_wdata_o;
  logic [BW-1:0] data_be_o;
  logic          data_gnt_i = 1'b1;
  logic          data_r_valid_i = 1'b0;
  logic [DW-1:0] data_r_rdata_i = '0;
  logic          err_o;

  mem_req_arbiter_2to1 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ch0_req_i      (ch0_req_i),
    .ch0_add_i      (ch0_add_i),
    .ch0_wen_i      (ch0_wen_i),
    .ch0_wdata_i    (ch0_wdata_i),
    .ch0_be_i       (ch0_be_i),
    .ch0_gnt_o      (ch0_gnt_o),
    .ch0_r_valid_o  (ch0_r_valid_o),
    .ch0_r_rdata_o  (ch0_r_rdata_o),
    .ch1_req_i      (ch1_req_i),
    .ch1_add_i      (ch1_add_i),
    .ch1_wen_i      (ch1_wen_i),
    .ch1_wdata_i    (ch1_wdata_i),
    .ch1_be_i       (ch1_be_i),
    .ch1_gnt_o      (ch1_gnt_o),
    .ch1_r_valid_o  (ch1_r_valid_o),
    .ch1_r_rdata_o  (ch1_r_rdata_o),
    .data_req_o     (data_req_o),
    .data_add_o     (data_add_o),
    .data_wen_o     (data_wen_o),
    .data_wdata_o   (data_wdata_o),
    .data_be_o      (data_be_o),
    .data_gnt_i     (data_gnt_i),
    .data_r_valid_i (data_r_valid_i),
    .data_r_rdata_i (data_r_rdata_i),
    .err_o          (err_o)
  );

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  typedef struct packed {
    logic          ch;
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] rdata;
  } rsp_exp_t;

  req_t          q0[$], q1[$];
  gnt_exp_t      exp_gnt[$];
  rsp_exp_t      exp_rsp[$];
  logic [DW-1:0] mem_q[$];
  logic          hold = 1'b0;
  logic          force_rv = 1'b0;
  int            compared = 0;
  int            mismatched = 0;
  int            gnt_seen = 0;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: grants every request, answers one cycle later unless held.
  always @(posedge clk) begin
    if (data_req_o && data_gnt_i) mem_q.push_back(rdata_of(data_add_o));
    if (force_rv) begin
      data_r_valid_i <= 1'b1;
      data_r_rdata_i <= 32'hDEAD_BEEF;
    end else if (!hold && mem_q.size() > 0) begin
      data_r_valid_i <= 1'b1;
      data_r_rdata_i <= mem_q.pop_front();
    end else begin
      data_r_valid_i <= 1'b0;
    end
  end

  // Channel drivers: hold each request stable until its grant is seen.
  initial begin : drv
    logic t0, t1;
    forever begin
      if (q0.size() > 0) begin
        ch0_req_i = 1'b1;
        {ch0_add_i, ch0_wen_i, ch0_wdata_i, ch0_be_i} = q0[0];
      end else begin
        ch0_req_i = 1'b0;
        {ch0_add_i, ch0_wen_i, ch0_wdata_i, ch0_be_i} = '0;
      end
      if (q1.size() > 0) begin
        ch1_req_i = 1'b1;
        {ch1_add_i, ch1_wen_i, ch1_wdata_i, ch1_be_i} = q1[0];
      end else begin
        ch1_req_i = 1'b0;
        {ch1_add_i, ch1_wen_i, ch1_wdata_i, ch1_be_i} = '0;
      end
      @(negedge clk);
      t0 = ch0_gnt_o;
      t1 = ch1_gnt_o;
      @(posedge clk);
      #1;
      if (t0 && q0.size() > 0) q0.delete(0);
      if (t1 && q1.size() > 0) q1.delete(0);
    end
  end

  // Monitor: every grant and every response is checked against the scoreboard.
  initial begin : mon
    gnt_exp_t ga, ge;
    rsp_exp_t ra, re;
    forever begin
      @(negedge clk);
      if (ch0_gnt_o || ch1_gnt_o) begin
        gnt_seen++;
        chk("gnt_onehot", 64'(ch0_gnt_o & ch1_gnt_o), 64'd0);
        ga = '{ch: ch1_gnt_o, add: data_add_o, wen: data_wen_o, wdata: data_wdata_o};
        if (exp_gnt.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_grant: got %0h expected none", ga);
        end else begin
          ge = exp_gnt.pop_front();
          chk("grant", 64'(ga), 64'(ge));
        end
      end
      if (ch0_r_valid_o || ch1_r_valid_o) begin
        chk("rvalid_onehot", 64'(ch0_r_valid_o & ch1_r_valid_o), 64'd0);
        chk("rdata_bcast", 64'(ch1_r_rdata_o), 64'(ch0_r_rdata_o));
        ra = '{ch: ch1_r_valid_o, rdata: ch0_r_rdata_o};
        if (exp_rsp.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rsp: got %0h expected none", ra);
        end else begin
          re = exp_rsp.pop_front();
          chk("response", 64'(ra), 64'(re));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic ch, input logic [AW-1:0] a, input logic wen,
                          input logic [DW-1:0] wd);
    req_t r;
    r = '{add: a, wen: wen, wdata: wd, be: 4'hF};
    if (ch) q1.push_back(r);
    else q0.push_back(r);
  endtask

  task automatic exp_g(input logic ch, input logic [AW-1:0] a, input logic wen,
                       input logic [DW-1:0] wd, input bit with_rsp);
    exp_gnt.push_back('{ch: ch, add: a, wen: wen, wdata: wd});
    if (with_rsp) exp_rsp.push_back('{ch: ch, rdata: rdata_of(a)});
  endtask

  task automatic do_reset(input string name);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk({name, "_rst_req"}, 64'(data_req_o), 64'd0);
    chk({name, "_rst_gnt"}, 64'({ch0_gnt_o, ch1_gnt_o, ch0_r_valid_o, ch1_r_valid_o}), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk({name, "_rst_err"}, 64'(err_o), 64'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mem_q.size() > 0 || exp_rsp.size() > 0 ||
            data_r_valid_i) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_in_time"}, 64'(n < 200), 64'd1);
  endtask

  task automatic wait_gnts(input string name, input int target);
    int n;
    n = 0;
    while (gnt_seen < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_gnts_in_time"}, 64'(gnt_seen), 64'(target));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int base, n, cnt;
    @(negedge clk);
    chk("por_req", 64'(data_req_o), 64'd0);
    do_reset("init");

    // Single store on ch0, response one cycle after the grant.
    base = gnt_seen;
    push_req(CH0, 10'h005, WEN_STORE, 32'h0000_00AA);
    exp_g(CH0, 10'h005, WEN_STORE, 32'h0000_00AA, 1'b1);
    n = 0;
    @(negedge clk);
    while (!ch0_gnt_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t031_gnt", 64'(ch0_gnt_o), 64'd1);
    @(negedge clk);
    chk("t031_rvalid_next", 64'(ch0_r_valid_o), 64'd1);
    wait_idle("t031");
    chk("t031_one_hs", 64'(gnt_seen - base), 64'd1);

    // Tie from reset: ch0 first, then alternating.
    do_reset("t032");
    push_req(CH0, 10'h010, WEN_LOAD, '0);
    push_req(CH0, 10'h011, WEN_LOAD, '0);
    push_req(CH1, 10'h020, WEN_LOAD, '0);
    push_req(CH1, 10'h021, WEN_LOAD, '0);
    exp_g(CH0, 10'h010, WEN_LOAD, '0, 1'b1);
    exp_g(CH1, 10'h020, WEN_LOAD, '0, 1'b1);
    exp_g(CH0, 10'h011, WEN_LOAD, '0, 1'b1);
    exp_g(CH1, 10'h021, WEN_LOAD, '0, 1'b1);
    wait_idle("t032");

    // Ten back-to-back loads: concurrent push/pop must never fill the FIFO.
    do_reset("t034");
    for (int i = 0; i < 5; i++) begin
      push_req(CH0, 10'(10'h030 + i), WEN_LOAD, '0);
      push_req(CH1, 10'(10'h040 + i), WEN_LOAD, '0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_g(CH0, 10'(10'h030 + i), WEN_LOAD, '0, 1'b1);
      exp_g(CH1, 10'(10'h040 + i), WEN_LOAD, '0, 1'b1);
    end
    n = 0;
    @(negedge clk);
    while (!(ch0_gnt_o || ch1_gnt_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ch0_gnt_o || ch1_gnt_o) cnt++;
      if (i < 9) @(negedge clk);
    end
    chk("t034_b2b_grants", 64'(cnt), 64'd10);
    wait_idle("t034");
    for (int i = 0; i < 3; i++) begin
      push_req(CH1, 10'(10'h050 + i), WEN_LOAD, '0);
      exp_g(CH1, 10'(10'h050 + i), WEN_LOAD, '0, 1'b1);
    end
    wait_idle("t034_ch1_only");

    // Withheld responses: stall at two outstanding, one response frees one slot.
    do_reset("t033");
    base = gnt_seen;
    hold = 1'b1;
    push_req(CH0, 10'h060, WEN_LOAD, '0);
    push_req(CH0, 10'h061, WEN_LOAD, '0);
    push_req(CH1, 10'h070, WEN_LOAD, '0);
    push_req(CH1, 10'h071, WEN_LOAD, '0);
    exp_g(CH0, 10'h060, WEN_LOAD, '0, 1'b1);
    exp_g(CH1, 10'h070, WEN_LOAD, '0, 1'b1);
    exp_g(CH0, 10'h061, WEN_LOAD, '0, 1'b1);
    exp_g(CH1, 10'h071, WEN_LOAD, '0, 1'b1);
    wait_gnts("t033_first2", base + 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t033_stall_req", 64'(data_req_o), 64'd0);
    end
    step();
    hold = 1'b0;
    step();
    hold = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("t033_one_new_gnt", 64'(gnt_seen - base), 64'd3);
    chk("t033_stall_again", 64'(data_req_o), 64'd0);
    step();
    hold = 1'b0;
    wait_idle("t033");
    chk("t033_all_gnts", 64'(gnt_seen - base), 64'd4);

    // Response with nothing outstanding: dropped, sticky error until reset.
    do_reset("t035");
    step();
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    @(negedge clk);
    chk("t035_rv_in", 64'(data_r_valid_i), 64'd1);
    chk("t035_no_rv", 64'({ch0_r_valid_o, ch1_r_valid_o}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t035_err_held", 64'(err_o), 64'd1);
    end
    do_reset("t035_clear");

    // Reset with two in flight: routes discarded, late responses flag an error.
    do_reset("t036");
    base = gnt_seen;
    hold = 1'b1;
    push_req(CH0, 10'h080, WEN_LOAD, '0);
    push_req(CH1, 10'h090, WEN_LOAD, '0);
    exp_g(CH0, 10'h080, WEN_LOAD, '0, 1'b0);
    exp_g(CH1, 10'h090, WEN_LOAD, '0, 1'b0);
    wait_gnts("t036_inflight", base + 2);
    do_reset("t036_mid");
    hold = 1'b0;
    wait_idle("t036_stale");
    @(negedge clk);
    chk("t036_stale_err", 64'(err_o), 64'd1);
    push_req(CH0, 10'h0A0, WEN_LOAD, '0);
    push_req(CH1, 10'h0B0, WEN_LOAD, '0);
    exp_g(CH0, 10'h0A0, WEN_LOAD, '0, 1'b1);
    exp_g(CH1, 10'h0B0, WEN_LOAD, '0, 1'b1);
    wait_idle("t036_tie");

    repeat (3) @(negedge clk);
    chk("end_gnt_queue", 64'(exp_gnt.size()), 64'd0);
    chk("end_rsp_queue", 64'(exp_rsp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
